// File: rtl/pe_sequencer_pkg.sv
// Shared parameters for the PE sequencer: state encoding, cr bit map and cr decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pe_sequencer_pkg;

    localparam int CR_W  = 13;
    localparam int CNT_W = 16;

    // cr bit positions, named by their effect on the PE.
    localparam int CR_HOLD      = 1;   // accumulator keeps/loads its own value
    localparam int CR_RELU      = 2;   // ReLU on the output path
    localparam int CR_OUT_SEL   = 3;   // output path selects the accumulator stream
    localparam int CR_MAC       = 5;   // acc += w * a
    localparam int CR_SHIFT     = 8;   // arithmetic right shift into the accumulator
    localparam int CR_OUT_SHIFT = 11;  // shift results out toward the array edge

    typedef logic [CR_W-1:0]  cr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_ACT   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // PE control word for a given state. Every bit not set here is 0; in
    // ACT that leaves cr_3/cr_9/cr_10/cr_11 low so the activation sees the
    // raw shifted accumulator before draining starts.
    function automatic cr_t cr_decode(input state_t st, input logic in_valid,
                                      input logic relu);
        cr_t cr;
        cr = '0;
        case (st)
            ST_MAC: begin
                // A missing beat must not corrupt the running sum: hold instead.
                if (in_valid) cr[CR_MAC]  = 1'b1;
                else          cr[CR_HOLD] = 1'b1;
            end
            ST_SHIFT: begin
                cr[CR_SHIFT] = 1'b1;
                cr[CR_HOLD]  = 1'b1;
            end
            ST_ACT: begin
                cr[CR_RELU] = relu;
            end
            ST_DRAIN: begin
                cr[CR_RELU]      = relu;
                cr[CR_OUT_SEL]   = 1'b1;
                cr[CR_OUT_SHIFT] = 1'b1;
                cr[CR_HOLD]      = 1'b1;
            end
            default: begin
                // IDLE, CLEAR, DONE: keep the accumulator untouched.
                cr[CR_HOLD] = 1'b1;
            end
        endcase
        return cr;
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Control/status bundle between a job issuer and the PE sequencer.
// Latency: n/a (wires only).
// Backpressure: none; in_valid qualifies each MAC beat, the sequencer stalls on it.
// Ports: master = job issuer (drives start/abort/cfg_*/in_valid),
//        slave  = sequencer (drives PE enables, cr, shift and status).
interface pe_sequencer_if;
    import pe_sequencer_pkg::*;

    logic        start;
    logic        abort;
    logic [15:0] cfg_num_macs;
    logic [7:0]  cfg_drain_len;
    logic [7:0]  cfg_shift;
    logic        cfg_relu;
    logic        in_valid;

    logic        enable_mac;
    logic        clear_mac;
    cr_t         cr;
    logic [7:0]  shift_fixed_point;
    logic        busy;
    logic        out_valid;
    logic        done;

    modport master (
        output start, abort, cfg_num_macs, cfg_drain_len, cfg_shift, cfg_relu, in_valid,
        input  enable_mac, clear_mac, cr, shift_fixed_point, busy, out_valid, done
    );

    modport slave (
        input  start, abort, cfg_num_macs, cfg_drain_len, cfg_shift, cfg_relu, in_valid,
        output enable_mac, clear_mac, cr, shift_fixed_point, busy, out_valid, done
    );

endinterface

// File: rtl/pe_sequencer.sv
// Job sequencer for a PE array: CLEAR, MAC over num_macs beats, SHIFT, ACT, DRAIN, DONE.
// Latency: 1 cycle start->CLEAR; job = 1 + beats(+stalls) + 1 + 1 + (drain_len-1) + 1 cycles.
// Backpressure: MAC stalls (hold, no count) while in_valid=0; abort returns to IDLE next cycle.
// Ports: clk, reset (async, active-low), bus (pe_sequencer_if.slave: start/abort/cfg_*/
//        in_valid in; enable_mac/clear_mac/cr/shift_fixed_point/busy/out_valid/done out).
module pe_sequencer
    import pe_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    pe_sequencer_if.slave  bus
);

    state_t      r_state;
    cnt_t        r_beat_cnt;
    cnt_t        r_drain_cnt;
    cnt_t        r_num_macs;
    logic [7:0]  r_drain_len;
    logic [7:0]  r_shift;
    logic        r_relu;

    state_t      w_state_nxt;
    cnt_t        w_beat_nxt;
    cnt_t        w_drain_nxt;
    cnt_t        w_beat_inc;
    cnt_t        w_drain_last;
    logic        w_capture;

    assign w_beat_inc   = r_beat_cnt + cnt_t'(1);
    // Index of the final DRAIN cycle; only consulted in DRAIN, where drain_len >= 2.
    assign w_drain_last = {8'd0, r_drain_len} - cnt_t'(1);

    assign bus.shift_fixed_point = r_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_num_macs  <= '0;
            r_drain_len <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_capture) begin
                r_num_macs  <= bus.cfg_num_macs;
                r_drain_len <= bus.cfg_drain_len;
                r_shift     <= bus.cfg_shift;
                r_relu      <= bus.cfg_relu;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat_cnt;
        w_drain_nxt    = r_drain_cnt;
        w_capture      = 1'b0;
        bus.busy       = (r_state != ST_IDLE);
        bus.out_valid  = 1'b0;
        bus.done       = 1'b0;
        bus.enable_mac = 1'b0;
        bus.clear_mac  = 1'b0;
        bus.cr         = cr_decode(r_state, bus.in_valid, r_relu);

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bus.clear_mac = 1'b1;
                w_beat_nxt    = '0;
                w_drain_nxt   = '0;
                w_state_nxt   = (r_num_macs == '0) ? ST_SHIFT : ST_MAC;
            end
            ST_MAC: begin
                bus.enable_mac = bus.in_valid;
                if (bus.in_valid) begin
                    if (r_beat_cnt != '1) w_beat_nxt = w_beat_inc;
                    if (w_beat_inc == r_num_macs) w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_state_nxt = ST_ACT;
            end
            ST_ACT: begin
                bus.out_valid = 1'b1;
                // ACT already produces the first output beat, so DRAIN covers the rest.
                if (r_drain_len <= 8'd1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drain_nxt = cnt_t'(1);
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.out_valid = 1'b1;
                if (r_drain_cnt >= w_drain_last) begin
                    w_state_nxt = ST_DONE;
                end else if (r_drain_cnt != '1) begin
                    w_drain_nxt = r_drain_cnt + cnt_t'(1);
                end
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort beats every transition: wipe the accumulator this cycle, freeze
        // the PE otherwise, and report nothing for the abandoned job.
        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state_nxt    = ST_IDLE;
            bus.clear_mac  = 1'b1;
            bus.enable_mac = 1'b0;
            bus.out_valid  = 1'b0;
            bus.done       = 1'b0;
            bus.cr         = cr_decode(ST_IDLE, 1'b0, 1'b0);
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: per-cycle expected status/enable/cr vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   en_cnt;
    int   ov_cnt;

    pe_sequencer_if bus();

    pe_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {busy, out_valid, done, enable_mac, clear_mac, cr}
    function automatic logic [17:0] ev(input logic b, input logic o, input logic d,
                                       input logic e, input logic c, input logic [12:0] cr);
        return {b, o, d, e, c, cr};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.busy, bus.out_valid, bus.done, bus.enable_mac, bus.clear_mac, bus.cr};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Drive this cycle's inputs, check the decoded outputs, then cross one rising edge.
    task automatic step(input string tag, input logic iv, input logic st, input logic [17:0] e);
        bus.in_valid = iv;
        bus.start    = st;
        #1;
        check(tag, {14'd0, obs()}, {14'd0, e});
        en_cnt += int'(bus.enable_mac);
        ov_cnt += int'(bus.out_valid);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] n, input logic [7:0] dl,
                           input logic [7:0] sh, input logic relu);
        bus.cfg_num_macs  = n;
        bus.cfg_drain_len = dl;
        bus.cfg_shift     = sh;
        bus.cfg_relu      = relu;
    endtask

    localparam logic [12:0] CR_HLD = 13'h002;
    localparam logic [12:0] CR_MC  = 13'h020;
    localparam logic [12:0] CR_SH  = 13'h102;
    localparam logic [12:0] CR_A1  = 13'h004;
    localparam logic [12:0] CR_A0  = 13'h000;
    localparam logic [12:0] CR_D1  = 13'h80E;
    localparam logic [12:0] CR_D0  = 13'h80A;

    initial begin
        clk    = 1'b0;
        reset  = 1'b0;
        checks = 0;
        errors = 0;
        en_cnt = 0;
        ov_cnt = 0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        set_cfg(16'd0, 8'd0, 8'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out", {14'd0, obs()}, {14'd0, ev(0,0,0,0,0,CR_HLD)});
        check("rst_sfp", {24'd0, bus.shift_fixed_point}, 32'd0);
        reset = 1'b1;

        // Nominal: 4 beats, drain 3, ReLU on; done 10 cycles after start
        set_cfg(16'd4, 8'd3, 8'd5, 1'b1);
        step("n_idle",  1, 1, ev(0,0,0,0,0,CR_HLD));
        step("n_clear", 1, 0, ev(1,0,0,0,1,CR_HLD));
        check("n_sfp", {24'd0, bus.shift_fixed_point}, 32'd5);
        for (int i = 0; i < 4; i++) step("n_mac", 1, 0, ev(1,0,0,1,0,CR_MC));
        step("n_shift", 1, 0, ev(1,0,0,0,0,CR_SH));
        step("n_act",   1, 0, ev(1,1,0,0,0,CR_A1));
        step("n_drain", 1, 0, ev(1,1,0,0,0,CR_D1));
        step("n_drain", 1, 0, ev(1,1,0,0,0,CR_D1));
        step("n_done",  0, 0, ev(1,0,1,0,0,CR_HLD));
        step("n_idle2", 0, 0, ev(0,0,0,0,0,CR_HLD));

        // Stalls 1,0,0,1,1 with 3 beats; start and cfg changes mid-job and in DONE
        set_cfg(16'd3, 8'd2, 8'd3, 1'b0);
        step("s_idle",  0, 1, ev(0,0,0,0,0,CR_HLD));
        step("s_clear", 0, 0, ev(1,0,0,0,1,CR_HLD));
        en_cnt = 0;
        step("s_mac1",  1, 0, ev(1,0,0,1,0,CR_MC));
        set_cfg(16'd3, 8'd9, 8'd77, 1'b1);
        step("s_stall", 0, 1, ev(1,0,0,0,0,CR_HLD));
        step("s_stall", 0, 0, ev(1,0,0,0,0,CR_HLD));
        step("s_mac2",  1, 1, ev(1,0,0,1,0,CR_MC));
        step("s_mac3",  1, 0, ev(1,0,0,1,0,CR_MC));
        check("s_en_cnt", en_cnt, 32'd3);
        step("s_shift", 1, 0, ev(1,0,0,0,0,CR_SH));
        step("s_act",   0, 0, ev(1,1,0,0,0,CR_A0));
        step("s_drain", 0, 0, ev(1,1,0,0,0,CR_D0));
        step("s_done",  0, 1, ev(1,0,1,0,0,CR_HLD));
        step("s_idle2", 0, 0, ev(0,0,0,0,0,CR_HLD));
        step("s_idle3", 0, 0, ev(0,0,0,0,0,CR_HLD));
        check("s_sfp", {24'd0, bus.shift_fixed_point}, 32'd3);

        // Zero beats, zero drain
        set_cfg(16'd0, 8'd0, 8'd2, 1'b1);
        ov_cnt = 0;
        step("z_idle",  0, 1, ev(0,0,0,0,0,CR_HLD));
        step("z_clear", 0, 0, ev(1,0,0,0,1,CR_HLD));
        step("z_shift", 0, 0, ev(1,0,0,0,0,CR_SH));
        step("z_act",   0, 0, ev(1,1,0,0,0,CR_A1));
        step("z_done",  0, 0, ev(1,0,1,0,0,CR_HLD));
        step("z_idle2", 0, 0, ev(0,0,0,0,0,CR_HLD));
        check("z_ov_cnt", ov_cnt, 32'd1);
        check("z_sfp", {24'd0, bus.shift_fixed_point}, 32'd2);

        // Abort at beat 2 of 8
        set_cfg(16'd8, 8'd3, 8'd4, 1'b0);
        step("a_idle",  0, 1, ev(0,0,0,0,0,CR_HLD));
        step("a_clear", 0, 0, ev(1,0,0,0,1,CR_HLD));
        step("a_mac1",  1, 0, ev(1,0,0,1,0,CR_MC));
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        #1;
        check("a_clr",  {31'd0, bus.clear_mac}, 32'd1);
        check("a_done", {31'd0, bus.done},      32'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        step("a_idle2", 1, 0, ev(0,0,0,0,0,CR_HLD));
        step("a_idle3", 0, 0, ev(0,0,0,0,0,CR_HLD));

        // Reset during DRAIN, then a fresh full job
        set_cfg(16'd1, 8'd4, 8'd9, 1'b1);
        step("r_idle",  0, 1, ev(0,0,0,0,0,CR_HLD));
        step("r_clear", 1, 0, ev(1,0,0,0,1,CR_HLD));
        step("r_mac",   1, 0, ev(1,0,0,1,0,CR_MC));
        step("r_shift", 0, 0, ev(1,0,0,0,0,CR_SH));
        step("r_act",   0, 0, ev(1,1,0,0,0,CR_A1));
        step("r_drain", 0, 0, ev(1,1,0,0,0,CR_D1));
        #1;
        reset = 1'b0;
        #1;
        check("r_rst_out", {14'd0, obs()}, {14'd0, ev(0,0,0,0,0,CR_HLD)});
        check("r_rst_sfp", {24'd0, bus.shift_fixed_point}, 32'd0);
        @(negedge clk);
        #1;
        check("r_rst_hold", {14'd0, obs()}, {14'd0, ev(0,0,0,0,0,CR_HLD)});
        reset = 1'b1;
        set_cfg(16'd2, 8'd2, 8'd6, 1'b0);
        step("f_idle",  0, 1, ev(0,0,0,0,0,CR_HLD));
        step("f_clear", 1, 0, ev(1,0,0,0,1,CR_HLD));
        step("f_mac",   1, 0, ev(1,0,0,1,0,CR_MC));
        step("f_mac",   1, 0, ev(1,0,0,1,0,CR_MC));
        step("f_shift", 0, 0, ev(1,0,0,0,0,CR_SH));
        step("f_act",   0, 0, ev(1,1,0,0,0,CR_A0));
        step("f_drain", 0, 0, ev(1,1,0,0,0,CR_D0));
        step("f_done",  0, 0, ev(1,0,1,0,0,CR_HLD));
        step("f_idle2", 0, 0, ev(0,0,0,0,0,CR_HLD));
        check("f_sfp", {24'd0, bus.shift_fixed_point}, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  one-cycle job request; sampled only in IDLE.
REQ-004 SHALL have port: abort  input  1  forces return to IDLE from any state.
REQ-005 SHALL have ports: cfg_num_macs  input  16  valid MAC beats per job; cfg_drain_len  input  8  output beats to drain.
REQ-006 SHALL have ports: cfg_shift  input  8  fixed-point shift; cfg_relu  input  1  ReLU enable.
REQ-007 SHALL have port: in_valid  input  1  activation/weight beat present on the PE array inputs this cycle.
REQ-008 SHALL have ports: enable_mac, clear_mac  output  1 each  PE array enables.
REQ-009 SHALL have port: cr  output  13  PE control bits; bit n drives PE cr_n.
REQ-010 SHALL have port: shift_fixed_point  output  8  latched cfg_shift.
REQ-011 SHALL have ports: busy, out_valid, done  output  1 each  status; done is a one-cycle pulse.

Function
REQ-012 SHALL implement states IDLE, CLEAR, MAC, SHIFT, ACT, DRAIN, DONE in a registered state machine.
REQ-013 SHALL, in IDLE, capture all cfg_* inputs on start=1 and enter CLEAR next cycle; start outside IDLE SHALL be ignored.
REQ-014 SHALL, in CLEAR (one cycle), drive clear_mac=1, then enter MAC, or SHIFT directly if num_macs=0.
REQ-015 SHALL, in MAC, drive cr with cr_5=1 and all other bits 0 when in_valid=1 (acc += w*a), with enable_mac=1.
REQ-016 SHALL, in MAC with in_valid=0, drive cr_1=1 (accumulator hold) and enable_mac=0, without advancing the beat counter.
REQ-017 SHALL count accepted beats and leave MAC after the cycle in which beat num_macs is accepted.
REQ-018 SHALL, in SHIFT (one cycle), drive cr_8=1 and cr_1=1 so the accumulator loads its arithmetic-right-shifted value.
REQ-019 SHALL, in ACT (one cycle), drive cr_2=cfg_relu, cr_3=0, cr_9=0, cr_10=0, cr_11=0; out_valid=1.
REQ-020 SHALL, in DRAIN, drive cr_2=cfg_relu, cr_3=1, cr_11=1, cr_1=1; out_valid=1; remain drain_len-1 cycles.
REQ-021 SHALL go ACT->DONE directly when drain_len is 0 or 1.
REQ-022 SHALL, in DONE (one cycle), pulse done=1 and return to IDLE; a start in that cycle SHALL be ignored.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL, on abort=1 in any non-IDLE state, drive clear_mac=1 that cycle and enter IDLE next cycle with no done pulse; abort SHALL take priority over all transitions.
REQ-025 SHALL drive all cr bits 0 and enable_mac=0 in IDLE and DONE, except cr_1=1 (hold accumulator).
REQ-026 SHALL decode outputs combinationally from the state register (plus in_valid in MAC); counters SHALL be 16 bits, non-wrapping.

Reset
REQ-027 SHALL, while reset=0, hold state=IDLE, counters 0, latched cfg 0, shift_fixed_point=0.
REQ-028 SHALL, during and after reset, present busy=0, done=0, out_valid=0, enable_mac=0, clear_mac=0, cr=13'b0_0000_0000_0010.
REQ-029 SHALL, on reset asserted mid-job, abandon the job without a done pulse.

Structure
REQ-030 SHALL take the state enum, cr bit-index constants and CR_* width from the shared parameters package.
REQ-031 SHALL be a single module; the cr decode MAY be a function in the package; no sub-module.

Verification
REQ-032 Nominal: num_macs=4, in_valid always 1, drain_len=3 -> CLEAR 1 cycle, MAC 4, SHIFT 1, ACT 1, DRAIN 2, done at cycle 10 after start.
REQ-033 Stalls: num_macs=3, in_valid=1,0,0,1,1 -> MAC lasts 5 cycles, cr_1=1 on the two stall cycles, enable_mac high exactly 3 cycles.
REQ-034 Zero cases: num_macs=0, drain_len=0 -> CLEAR->SHIFT->ACT->DONE, out_valid high exactly 1 cycle.
REQ-035 Abort in MAC at beat 2 of 8 -> clear_mac=1 that cycle, IDLE next cycle, done never asserted, busy falls.
REQ-036 Start while busy and start in DONE -> ignored; cfg change mid-job does not alter shift_fixed_point or drain length.
REQ-037 Reset asserted in DRAIN -> outputs immediately at REQ-028 values; a fresh start after release runs a full job.
